// File: rtl/s2p_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, DATA_W payload bits LSB first, optional parity, stop bit.
// Define PARITY_CHECK_EN to expect a parity bit after the payload and report par_err.
module s2p_frame_rx #(
  parameter int DATA_W  = 4,
  parameter int ODD_PAR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              ser_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  if (DATA_W < 2 || DATA_W > 8 || ODD_PAR < 0 || ODD_PAR > 1) begin : g_bad_cfg
    $error("s2p_frame_rx: DATA_W must be 2..8 and ODD_PAR 0 or 1");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic              shift_en;
  logic              stop_ok;
  logic              stop_bad;
  logic              par_calc;

`ifdef PARITY_CHECK_EN
  logic par_q;
  logic par_cap;
  assign par_calc = ((^data_q) ^ par_q) != ODD_PAR[0];
`else
  assign par_calc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef PARITY_CHECK_EN
    par_cap  = 1'b0;
`endif
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!ser_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          par_cap = 1'b1;
          state_d = STOP;
        end
`endif
        STOP: begin
          stop_ok  = ser_in;
          stop_bad = !ser_in;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      if (shift_en) begin
        for (int unsigned i = 0; i < DATA_W; i++) begin
          if (cnt_q == CNT_W'(i)) data_q[i] <= ser_in;
        end
      end
`ifdef PARITY_CHECK_EN
      if (par_cap) par_q <= ser_in;
`endif
      if (stop_bad) frm_err <= 1'b1;
      // A completed frame wins over a plain pop: with out_ready high it replaces the held word.
      if (stop_ok && out_valid && !out_ready) begin
        ovr_err <= 1'b1;
      end else if (stop_ok) begin
        out_data  <= data_q;
        out_valid <= 1'b1;
        par_err   <= par_calc;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s2p_frame_rx.sv
// Directed testbench for s2p_frame_rx; stimulus follows the PARITY_CHECK_EN setting of the build.
module tb_s2p_frame_rx;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_en = 1'b0;
  logic          ser_in = 1'b1;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          par_err;
  logic          frm_err;
  logic          ovr_err;

  int   n_vec  = 0;
  int   n_miss = 0;
  logic rdy_base = 1'b0;
  logic ready_on_stop = 1'b0;

`ifdef PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  s2p_frame_rx #(.DATA_W(DW), .ODD_PAR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .ser_in    (ser_in),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .ovr_err   (ovr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Holds b on the line for p cycles; bit_en is asserted on the last of them.
  task automatic send_bit(input logic b, input int p, input logic rdy);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      ser_in    = b;
      bit_en    = (i == p - 1);
      out_ready = rdy;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop, input int p);
    send_bit(1'b0, p, rdy_base);
    for (int i = 0; i < DW; i++) send_bit(d[i], p, rdy_base);
    if (PAR_EN) send_bit(par, p, rdy_base);
    send_bit(stop, p, rdy_base | ready_on_stop);
  endtask

  task automatic settle();
    @(negedge clk);
    bit_en    = 1'b0;
    ser_in    = 1'b1;
    out_ready = rdy_base;
  endtask

  task automatic pop(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = rdy_base;
    check(tag, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_data",  {28'd0, out_data}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_par",   {31'd0, par_err}, 32'd0);
    check("rst_frm",   {31'd0, frm_err}, 32'd0);
    check("rst_ovr",   {31'd0, ovr_err}, 32'd0);
    rst_n = 1'b1;

    // good frame, correct parity
    send_frame(4'b1100, 1'b0, 1'b1, 1);
    settle();
    check("f1_data",  {28'd0, out_data}, 32'hC);
    check("f1_valid", {31'd0, out_valid}, 32'd1);
    check("f1_par",   {31'd0, par_err}, 32'd0);
    pop("f1_pop");

    // same payload, wrong parity bit
    send_frame(4'b1100, 1'b1, 1'b1, 1);
    settle();
    check("f2_data", {28'd0, out_data}, 32'hC);
    check("f2_par",  {31'd0, par_err}, {31'd0, PAR_EN});
    pop("f2_pop");

    // bad stop bit, then a good frame
    send_frame(4'b1111, 1'b0, 1'b0, 1);
    settle();
    check("f3_frm",   {31'd0, frm_err}, 32'd1);
    check("f3_valid", {31'd0, out_valid}, 32'd0);
    send_frame(4'b0101, 1'b0, 1'b1, 1);
    settle();
    check("f4_data",  {28'd0, out_data}, 32'h5);
    check("f4_valid", {31'd0, out_valid}, 32'd1);
    check("f4_par",   {31'd0, par_err}, 32'd0);
    check("f4_frm",   {31'd0, frm_err}, 32'd1);
    pop("f4_pop");

    // word replaced when out_ready is high on the completing edge
    send_frame(4'b1001, 1'b0, 1'b1, 1);
    ready_on_stop = 1'b1;
    send_frame(4'b0110, 1'b0, 1'b1, 1);
    ready_on_stop = 1'b0;
    settle();
    check("rep_data",  {28'd0, out_data}, 32'h6);
    check("rep_valid", {31'd0, out_valid}, 32'd1);
    check("rep_ovr",   {31'd0, ovr_err}, 32'd0);
    pop("rep_pop");

    // overrun: back-to-back frames, downstream stalled
    send_frame(4'b0011, 1'b0, 1'b1, 1);
    send_frame(4'b1010, 1'b0, 1'b1, 1);
    settle();
    check("ovr_data",  {28'd0, out_data}, 32'h3);
    check("ovr_valid", {31'd0, out_valid}, 32'd1);
    check("ovr_flag",  {31'd0, ovr_err}, 32'd1);
    pop("ovr_pop");
    check("ovr_sticky", {31'd0, ovr_err}, 32'd1);

    // reset after two data bits, checked before the next clock edge
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    @(negedge clk);
    bit_en = 1'b0;
    ser_in = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("ar_data", {28'd0, out_data}, 32'd0);
    check("ar_frm",  {31'd0, frm_err}, 32'd0);
    check("ar_ovr",  {31'd0, ovr_err}, 32'd0);
    check("ar_par",  {31'd0, par_err}, 32'd0);
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(4'b0110, 1'b0, 1'b1, 1);
    settle();
    check("ar_f_data",  {28'd0, out_data}, 32'h6);
    check("ar_f_valid", {31'd0, out_valid}, 32'd1);
    check("ar_f_frm",   {31'd0, frm_err}, 32'd0);
    pop("ar_f_pop");

    // slow strobe, downstream always ready
    rdy_base = 1'b1;
    send_frame(4'b1100, 1'b0, 1'b1, 4);
    check("slow_pre_valid", {31'd0, out_valid}, 32'd0);
    settle();
    check("slow_data",  {28'd0, out_data}, 32'hC);
    check("slow_valid", {31'd0, out_valid}, 32'd1);
    check("slow_par",   {31'd0, par_err}, 32'd0);
    @(negedge clk);
    check("slow_valid_1cyc", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
